// File: rtl/tt6581_pkg.sv
// Shared constants for the voice sequencer: voice count, index/level widths and FSM encodings.
// The mute-skip helper exists only when VOICE_SEQ_MUTE_EN is defined.
package tt6581_pkg;

   localparam int NUM_VOICES = 3;
   localparam int VIDX_W     = 2;
   localparam int ENV_W      = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

`ifdef VOICE_SEQ_MUTE_EN
   // Returns {none_left, index} of the first unmuted voice at or above 'from'.
   function automatic logic [VIDX_W:0] next_unmuted(input logic [NUM_VOICES-1:0] mute,
                                                     input int                    from);
      logic [VIDX_W:0] r;
      r = {1'b1, {VIDX_W{1'b0}}};
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         if (v >= from && !mute[v]) r = {1'b0, VIDX_W'(v)};
      end
      return r;
   endfunction
`endif

endpackage

// File: rtl/voice_sequencer.sv
// Frame sequencer for the shared envelope generator: walks the voices once per sample tick.
// Optional VOICE_SEQ_MUTE_EN adds mute_i; muted voices are skipped and their level slot is zeroed.
//
// state | meaning
// IDLE  | waiting for sample_tick_i
// START | one-cycle start pulse for the current voice
// WAIT  | holding voice/gate until the envelope block reports ready
// DONE  | one-cycle frame_done_o; env_o holds a full frame
module voice_sequencer
   import tt6581_pkg::*;
(
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        sample_tick_i,
   input  logic [NUM_VOICES-1:0]       gate_i,
`ifdef VOICE_SEQ_MUTE_EN
   input  logic [NUM_VOICES-1:0]       mute_i,
`endif
   input  logic                        clr_overrun_i,
   output logic                        env_start_o,
   output logic [VIDX_W-1:0]           env_voice_o,
   output logic                        env_gate_o,
   input  logic                        env_ready_i,
   input  logic [ENV_W-1:0]            env_raw_i,
   output logic [ENV_W*NUM_VOICES-1:0] env_o,
   output logic                        frame_done_o,
   output logic                        busy_o,
   output logic                        overrun_o
);

   logic [1:0]                  state_q, state_d;
   logic [VIDX_W-1:0]           voice_q, voice_d;
   logic [NUM_VOICES-1:0]       gate_q, gate_d;
   logic [ENV_W*NUM_VOICES-1:0] env_q, env_d;
   logic                        overrun_q, overrun_d;
`ifdef VOICE_SEQ_MUTE_EN
   logic [NUM_VOICES-1:0]       mute_q, mute_d;
   logic [VIDX_W:0]             nxt_first, nxt_after;
`endif

   always_comb begin
      state_d = state_q;
      voice_d = voice_q;
      gate_d  = gate_q;
      env_d   = env_q;
`ifdef VOICE_SEQ_MUTE_EN
      mute_d    = mute_q;
      nxt_first = next_unmuted(mute_i, 0);
      nxt_after = next_unmuted(mute_q, int'(voice_q) + 1);
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (sample_tick_i) begin
               gate_d  = gate_i;
               voice_d = '0;
`ifdef VOICE_SEQ_MUTE_EN
               mute_d = mute_i;
               for (int v = 0; v < NUM_VOICES; v++) begin
                  if (mute_i[v]) env_d[v*ENV_W +: ENV_W] = '0;
               end
               if (nxt_first[VIDX_W]) begin
                  state_d = ST_DONE;
               end else begin
                  voice_d = nxt_first[VIDX_W-1:0];
                  state_d = ST_START;
               end
`else
               state_d = ST_START;
`endif
            end
         end
         ST_START: state_d = ST_WAIT;
         ST_WAIT: begin
            if (env_ready_i) begin
               env_d[int'(voice_q)*ENV_W +: ENV_W] = env_raw_i;
`ifdef VOICE_SEQ_MUTE_EN
               if (nxt_after[VIDX_W]) begin
                  state_d = ST_DONE;
               end else begin
                  voice_d = nxt_after[VIDX_W-1:0];
                  state_d = ST_START;
               end
`else
               if (voice_q == VIDX_W'(NUM_VOICES - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  voice_d = voice_q + 1'b1;
                  state_d = ST_START;
               end
`endif
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // A tick landing while busy (DONE included) outranks a simultaneous clear.
      overrun_d = overrun_q;
      if (clr_overrun_i) overrun_d = 1'b0;
      if (sample_tick_i && state_q != ST_IDLE) overrun_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         voice_q   <= '0;
         gate_q    <= '0;
         env_q     <= '0;
         overrun_q <= 1'b0;
`ifdef VOICE_SEQ_MUTE_EN
         mute_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         voice_q   <= voice_d;
         gate_q    <= gate_d;
         env_q     <= env_d;
         overrun_q <= overrun_d;
`ifdef VOICE_SEQ_MUTE_EN
         mute_q    <= mute_d;
`endif
      end
   end

   assign env_start_o  = (state_q == ST_START);
   assign env_voice_o  = voice_q;
   assign env_gate_o   = gate_q[voice_q];
   assign env_o        = env_q;
   assign frame_done_o = (state_q == ST_DONE);
   assign busy_o       = (state_q != ST_IDLE);
   assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_voice_sequencer.sv
// Directed bench for voice_sequencer with a latency-programmable envelope-block model.
// Cycle numbers are relative to the cycle in which the frame's tick is driven (cycle 0).
module tb_voice_sequencer;
   import tt6581_pkg::*;

   logic                        clk = 1'b0;
   logic                        rst, tick, clr, rdy;
   logic [NUM_VOICES-1:0]       gate;
   logic [7:0]                  raw;
   logic                        start_o, gate_o, done, busy, ovr;
   logic [1:0]                  voice_o;
   logic [8*NUM_VOICES-1:0]     env;
`ifdef VOICE_SEQ_MUTE_EN
   logic [NUM_VOICES-1:0]       mute;
`endif

   voice_sequencer dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .sample_tick_i (tick),
      .gate_i        (gate),
`ifdef VOICE_SEQ_MUTE_EN
      .mute_i        (mute),
`endif
      .clr_overrun_i (clr),
      .env_start_o   (start_o),
      .env_voice_o   (voice_o),
      .env_gate_o    (gate_o),
      .env_ready_i   (rdy),
      .env_raw_i     (raw),
      .env_o         (env),
      .frame_done_o  (done),
      .busy_o        (busy),
      .overrun_o     (ovr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int t0  = 0;
   always @(posedge clk) cyc++;

   // Envelope block model: ready arrives lat[v] cycles after the start cycle.
   int          lat [4];
   logic [7:0]  lvl [4];
   int          cnt;
   logic [1:0]  cur;
   always @(posedge clk) begin
      if (rst) begin
         rdy <= 1'b0; raw <= '0; cnt <= 0; cur <= '0;
      end else begin
         rdy <= 1'b0; raw <= '0;
         if (start_o) begin
            cnt <= lat[voice_o] - 1; cur <= voice_o;
         end else if (cnt == 1) begin
            cnt <= 0; rdy <= 1'b1; raw <= lvl[cur];
         end else if (cnt != 0) begin
            cnt <= cnt - 1;
         end
      end
   end

   int         st_cyc[$];
   logic [1:0] st_voice[$];
   logic       st_gate[$];
   int         dn_cyc[$];
   int         busy_cnt;
   always @(negedge clk) begin
      if (start_o) begin
         st_cyc.push_back(cyc - t0); st_voice.push_back(voice_o); st_gate.push_back(gate_o);
      end
      if (done) dn_cyc.push_back(cyc - t0);
      if (busy) busy_cnt++;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic goto(input int c);
      while (cyc < t0 + c) begin @(posedge clk); #1; end
   endtask

   task automatic clear_log();
      st_cyc.delete(); st_voice.delete(); st_gate.delete(); dn_cyc.delete(); busy_cnt = 0;
   endtask

   task automatic fire_tick();
      clear_log();
      tick = 1'b1; t0 = cyc;
      @(posedge clk); #1;
      tick = 1'b0;
   endtask

   function automatic int first_done();
      return (dn_cyc.size() == 1) ? dn_cyc[0] : -1;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0; t0 = cyc;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (env !== '0) begin n_fail++; $display("FAIL reset_env: got %h expected 0", env); end
      n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", ovr); end
      n_checks++; if (start_o !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", start_o); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++; if (voice_o !== 2'd0) begin n_fail++; $display("FAIL reset_voice: got %0d expected 0", voice_o); end
      n_checks++; if (gate_o !== 1'b0) begin n_fail++; $display("FAIL reset_gate: got %b expected 0", gate_o); end
   endtask

   task automatic test_basic();
      int exp_c[3] = '{1, 5, 9};
      gate = 3'b111;
      lvl[0] = 8'h11; lvl[1] = 8'h22; lvl[2] = 8'h33;
      fire_tick();
      goto(4);
      n_checks++; if (env !== 24'h0) begin n_fail++; $display("FAIL basic_slot_before: got %h expected 000000", env); end
      goto(5);
      n_checks++; if (env !== 24'h000011) begin n_fail++; $display("FAIL basic_slot_after: got %h expected 000011", env); end
      goto(13);
      n_checks++; if (done !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_done13: got done=%b busy=%b expected 1 1", done, busy); end
      goto(14);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle14: got busy=%b expected 0", busy); end
      goto(16);
      n_checks++; if (st_cyc.size() !== 3) begin n_fail++; $display("FAIL basic_nstarts: got %0d expected 3", st_cyc.size()); end
      for (int i = 0; i < st_cyc.size() && i < 3; i++) begin
         n_checks++;
         if (st_cyc[i] !== exp_c[i] || st_voice[i] !== 2'(i) || st_gate[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_start%0d: got cyc=%0d voice=%0d gate=%b expected cyc=%0d voice=%0d gate=1", i, st_cyc[i], st_voice[i], st_gate[i], exp_c[i], i);
         end
      end
      n_checks++; if (first_done() !== 13) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 13", first_done()); end
      n_checks++; if (env !== 24'h332211) begin n_fail++; $display("FAIL basic_env: got %h expected 332211", env); end
      n_checks++; if (busy_cnt !== 13) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 13", busy_cnt); end
   endtask

   task automatic test_stall();
      int exp_c[3] = '{1, 5, 14};
      lvl[0] = 8'h44; lvl[1] = 8'h55; lvl[2] = 8'h66;
      lat[1] = 8;
      fire_tick();
      for (int c = 6; c <= 13; c++) begin
         goto(c);
         n_checks++;
         if (voice_o !== 2'd1 || start_o !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold c%0d: got voice=%0d start=%b expected 1 0", c, voice_o, start_o);
         end
      end
      goto(20);
      n_checks++; if (st_cyc.size() !== 3) begin n_fail++; $display("FAIL stall_nstarts: got %0d expected 3", st_cyc.size()); end
      for (int i = 0; i < st_cyc.size() && i < 3; i++) begin
         n_checks++;
         if (st_cyc[i] !== exp_c[i]) begin n_fail++; $display("FAIL stall_start%0d: got %0d expected %0d", i, st_cyc[i], exp_c[i]); end
      end
      n_checks++; if (first_done() !== 18) begin n_fail++; $display("FAIL stall_done_cycle: got %0d expected 18", first_done()); end
      n_checks++; if (env !== 24'h665544) begin n_fail++; $display("FAIL stall_env: got %h expected 665544", env); end
      lat[1] = 3;
      lvl[0] = 8'h11; lvl[1] = 8'h22; lvl[2] = 8'h33;
   endtask

   task automatic test_overrun();
      fire_tick();
      goto(6);
      n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_before: got %b expected 0", ovr); end
      tick = 1'b1; @(posedge clk); #1 tick = 1'b0;
      n_checks++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_set7: got %b expected 1", ovr); end
      goto(15);
      n_checks++; if (first_done() !== 13 || st_cyc.size() !== 3) begin n_fail++; $display("FAIL ovr_frame: got done=%0d starts=%0d expected 13 3", first_done(), st_cyc.size()); end
      n_checks++; if (env !== 24'h332211) begin n_fail++; $display("FAIL ovr_env: got %h expected 332211", env); end
      clr = 1'b1; @(posedge clk); #1 clr = 1'b0;
      n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", ovr); end
      fire_tick();
      goto(3);
      tick = 1'b1; clr = 1'b1; @(posedge clk); #1 tick = 1'b0; clr = 1'b0;
      n_checks++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins: got %b expected 1", ovr); end
      goto(15);
      n_checks++; if (first_done() !== 13) begin n_fail++; $display("FAIL ovr_frame2: got %0d expected 13", first_done()); end
      clr = 1'b1; @(posedge clk); #1 clr = 1'b0;
      n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clear2: got %b expected 0", ovr); end
   endtask

   task automatic test_back_to_back();
      fire_tick();
      goto(13);
      tick = 1'b1; @(posedge clk); #1;
      n_checks++; if (ovr !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done_tick: got ovr=%b busy=%b expected 1 0", ovr, busy); end
      clear_log(); t0 = cyc;
      @(posedge clk); #1 tick = 1'b0;
      n_checks++; if (busy !== 1'b1 || start_o !== 1'b1) begin n_fail++; $display("FAIL b2b_accept14: got busy=%b start=%b expected 1 1", busy, start_o); end
      goto(15);
      n_checks++; if (first_done() !== 13 || st_cyc.size() !== 3) begin n_fail++; $display("FAIL b2b_frame: got done=%0d starts=%0d expected 13 3", first_done(), st_cyc.size()); end
      clr = 1'b1; @(posedge clk); #1 clr = 1'b0;
      n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL b2b_clear: got %b expected 0", ovr); end
   endtask

   task automatic test_gate_latch();
      gate = 3'b111;
      fire_tick();
      goto(3);
      gate = 3'b000;
      goto(15);
      n_checks++; if (st_gate.size() !== 3) begin n_fail++; $display("FAIL gate_nstarts: got %0d expected 3", st_gate.size()); end
      for (int i = 0; i < st_gate.size() && i < 3; i++) begin
         n_checks++; if (st_gate[i] !== 1'b1) begin n_fail++; $display("FAIL gate_latched%0d: got %b expected 1", i, st_gate[i]); end
      end
      fire_tick();
      goto(15);
      for (int i = 0; i < st_gate.size() && i < 3; i++) begin
         n_checks++; if (st_gate[i] !== 1'b0) begin n_fail++; $display("FAIL gate_next%0d: got %b expected 0", i, st_gate[i]); end
      end
      gate = 3'b111;
   endtask

   task automatic test_reset_mid();
      fire_tick();
      goto(6);
      rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
      n_checks++; if (busy !== 1'b0 || env !== '0 || start_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: got busy=%b env=%h start=%b expected 0 000000 0", busy, env, start_o); end
      goto(20);
      n_checks++; if (dn_cyc.size() !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d strobes expected 0", dn_cyc.size()); end
      fire_tick();
      goto(15);
      n_checks++; if (first_done() !== 13 || st_cyc.size() !== 3) begin n_fail++; $display("FAIL rstmid_rerun: got done=%0d starts=%0d expected 13 3", first_done(), st_cyc.size()); end
      n_checks++; if (env !== 24'h332211) begin n_fail++; $display("FAIL rstmid_env: got %h expected 332211", env); end
   endtask

`ifdef VOICE_SEQ_MUTE_EN
   task automatic test_mute();
      mute = 3'b010;
      fire_tick();
      goto(12);
      n_checks++; if (st_cyc.size() !== 2) begin n_fail++; $display("FAIL mute_nstarts: got %0d expected 2", st_cyc.size()); end
      if (st_cyc.size() == 2) begin
         n_checks++;
         if (st_cyc[0] !== 1 || st_voice[0] !== 2'd0 || st_cyc[1] !== 5 || st_voice[1] !== 2'd2) begin
            n_fail++; $display("FAIL mute_starts: got %0d/v%0d %0d/v%0d expected 1/v0 5/v2", st_cyc[0], st_voice[0], st_cyc[1], st_voice[1]);
         end
      end
      n_checks++; if (first_done() !== 9) begin n_fail++; $display("FAIL mute_done: got %0d expected 9", first_done()); end
      n_checks++; if (env !== 24'h330011) begin n_fail++; $display("FAIL mute_env: got %h expected 330011", env); end
      mute = 3'b111;
      fire_tick();
      goto(4);
      n_checks++; if (first_done() !== 1 || st_cyc.size() !== 0) begin n_fail++; $display("FAIL mute_all: got done=%0d starts=%0d expected 1 0", first_done(), st_cyc.size()); end
      n_checks++; if (env !== 24'h0) begin n_fail++; $display("FAIL mute_all_env: got %h expected 000000", env); end
      mute = 3'b000;
   endtask
`endif

   initial begin
      rst = 1'b1; tick = 1'b0; clr = 1'b0; gate = '0;
`ifdef VOICE_SEQ_MUTE_EN
      mute = '0;
`endif
      for (int i = 0; i < 4; i++) begin lat[i] = 3; lvl[i] = '0; end
      test_reset();
      test_basic();
      test_stall();
      test_overrun();
      test_back_to_back();
      test_gate_latch();
      test_reset_mid();
`ifdef VOICE_SEQ_MUTE_EN
      test_mute();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/voice_sequencer.md
# voice_sequencer

Frame-level controller for the shared, time-multiplexed envelope generator. On each sample tick it walks voices 0..NUM_VOICES-1, drives voice index, latched gate and start into the envelope block, waits for its ready strobe, and captures each voice's 8-bit envelope level. After the last voice it presents all levels together with a one-cycle frame-done strobe to the mixer. It sits between the sample-rate timebase and the envelope datapath.

## Interface
- NUM_VOICES, 3, voices processed per frame; legal range 2..4, bounded by the 2-bit voice index.
- clk_i  in  1  system clock.
- rst_i  in  1  reset, active-high, synchronous to clk_i.
- sample_tick_i  in  1  one-cycle pulse that starts a frame.
- gate_i  in  NUM_VOICES  per-voice gate bits from register file; bit v belongs to voice v.
- clr_overrun_i  in  1  clears overrun_o.
- env_start_o  out  1  start pulse to the envelope block.
- env_voice_o  out  2  active voice index to the envelope block.
- env_gate_o  out  1  latched gate of the active voice.
- env_ready_i  in  1  one-cycle completion strobe from the envelope block.
- env_raw_i  in  8  envelope level of the active voice, valid while env_ready_i is high.
- env_o  out  8*NUM_VOICES  captured levels; bits [8v+7:8v] belong to voice v.
- frame_done_o  out  1  one-cycle strobe; env_o holds a complete frame.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- overrun_o  out  1  sticky; a tick arrived while busy.

## Operation
- FSM states: IDLE, START, WAIT, DONE.
- IDLE: on sample_tick_i, latch gate_i into gate_q, clear voice counter to 0, go to START.
- START: env_start_o=1 for exactly this cycle, go to WAIT.
- WAIT: hold outputs until env_ready_i=1. On ready, write env_raw_i into slot env_voice_o of env_o. If the voice is NUM_VOICES-1, go to DONE. Otherwise increment the voice and go to START.
- DONE: frame_done_o=1, go to IDLE.
- env_voice_o and env_gate_o (gate_q[voice]) hold stable from START through the cycle in which ready is seen. The envelope block reads them combinationally during its update cycle.
- env_ready_i outside WAIT is ignored.
- gate_i changes mid-frame do not affect the current frame.
- Overrun:
  - sample_tick_i while not in IDLE, including in DONE, is dropped and sets overrun_o.
  - clr_overrun_i clears overrun_o.
  - If a set and a clear occur in the same cycle, the set wins.
- No timeout. The envelope block always completes.
- Reset values: FSM IDLE, voice 0, gate_q 0, env_o 0, overrun_o 0, and every strobe 0.
- Reset mid-frame abandons the frame with no frame_done_o. The envelope block shares the reset, so both restart consistently.

## Timing
- Tick sampled at cycle 0; START at cycle 1.
- The envelope block takes at least 3 cycles from start to ready (update, multiply, done). It returns to idle the cycle after ready, which is exactly when the next START asserts.
- Minimum per voice: 4 cycles. With NUM_VOICES=3 and zero-wait multiply, ready occurs at cycles 4, 8 and 12, and frame_done_o fires at cycle 13. busy_o is high in cycles 1..13.
- env_o slot v updates the cycle after the corresponding ready. Earlier slots stay stable until overwritten in the next frame.
- Earliest acceptable next tick: cycle 14, i.e. the first IDLE cycle after DONE.

## Configuration
- VOICE_SEQ_MUTE_EN defined:
  - Adds input mute_i [NUM_VOICES-1:0], latched at the tick alongside gate_i.
  - A muted voice gets no start pulse; its envelope state is frozen and its env_o slot is written 0.
  - The voice counter skips muted voices in the same cycle. From IDLE or WAIT it goes directly to the next unmuted voice's START, or to DONE if none remain.
  - All voices muted: tick at cycle 0, DONE at cycle 1.
- VOICE_SEQ_MUTE_EN undefined: no mute_i port; every voice is processed every frame.

## Structure
- Shared package tt6581_pkg holds NUM_VOICES, the voice index width (2), the envelope level width (8), and the sequencer state enum.
- No sub-module. The FSM, counter, capture registers and overrun flag are a single module, roughly 150 lines.

## Test plan
- Tick with gate_i=3'b111 and an envelope model returning ready 3 cycles after start, with levels 0x11/0x22/0x33 -> three starts at cycles 1/5/9 with voice 0/1/2; frame_done_o at 13; env_o=0x332211.
- Envelope model with a 5-cycle multiply stall on voice 1 -> env_voice_o holds 1 and env_start_o stays low during the stall; frame_done_o is delayed by 5 cycles.
- Second tick at cycle 6 -> frame completes unchanged; overrun_o=1 from cycle 7; clr_overrun_i pulse -> 0; tick and clear in the same cycle while busy -> overrun_o stays 1.
- gate_i toggles from 111 to 000 at cycle 3 -> env_gate_o=1 for all three voices this frame; the next frame drives 0.
- rst_i pulse at cycle 6 -> next cycle busy_o=0, env_o=0, no frame_done_o; a new tick then runs a full frame normally.
- VOICE_SEQ_MUTE_EN with mute_i=3'b010 -> starts only for voices 0 and 2 (cycles 1 and 5); slot 1 is 0x00; frame_done_o at 9. mute_i=3'b111 -> frame_done_o at cycle 1 with no starts.
